// File: rtl/special_gate_arbiter.sv
// Round-robin arbiter that time-shares one bank of mux-based XOR/XNOR gates
// among N_REQ requesters and returns each result with its owner's ID.

module special_gate (
    input  logic a_i,
    input  logic b_i,
    input  logic op_i,
    output logic y_o
);
    logic b_eff_s;

    // op flips the data input of the mux, turning XOR into XNOR
    assign b_eff_s = op_i ? ~b_i : b_i;
    assign y_o     = a_i ? ~b_eff_s : b_eff_s;
endmodule

module special_gate_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int W     = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    input  logic [N_REQ-1:0]   op_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               res_valid,
    output logic [W-1:0]       res_data,
    output logic [IDW-1:0]     res_id,
    input  logic               res_ready,
    output logic [15:0]        done_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]     a_l_q, a_l_d;
    logic [W-1:0]     b_l_q, b_l_d;
    logic             op_l_q, op_l_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [15:0]      done_q, done_d;

    logic             sel_found_s;
    logic [IDW-1:0]   sel_idx_s;
    logic [IDW-1:0]   ptr_next_s;
    logic [W-1:0]     a_sel_s;
    logic [W-1:0]     b_sel_s;
    logic             op_sel_s;
    logic [W-1:0]     gate_s;

    // Rotating search: first set req bit at or above ptr, wrapping modulo N_REQ
    always_comb begin
        int unsigned cand;
        sel_found_s = 1'b0;
        sel_idx_s   = {IDW{1'b0}};
        a_sel_s     = {W{1'b0}};
        b_sel_s     = {W{1'b0}};
        op_sel_s    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr_q) + i) % N_REQ;
            if (!sel_found_s && req[cand]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDW'(cand);
                a_sel_s     = a_in[cand*W +: W];
                b_sel_s     = b_in[cand*W +: W];
                op_sel_s    = op_in[cand];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Pointer moves one past the winner so the winner drops to lowest priority
    always_comb begin
        if (sel_idx_s == IDW'(N_REQ - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = sel_idx_s + IDW'(1);
        end
    end

    genvar g;
    generate
        for (g = 0; g < W; g++) begin : g_bank
            special_gate u_gate (
                .a_i  (a_l_q[g]),
                .b_i  (b_l_q[g]),
                .op_i (op_l_q),
                .y_o  (gate_s[g])
            );
        end
    endgenerate

    // Sequencer next-state: grant in IDLE, evaluate in EXEC, hand off in HOLD
    always_comb begin
        state_d     = state_q;
        gnt_d       = {N_REQ{1'b0}};
        a_l_d       = a_l_q;
        b_l_d       = b_l_q;
        op_l_d      = op_l_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    gnt_d[sel_idx_s] = 1'b1;
                    a_l_d            = a_sel_s;
                    b_l_d            = b_sel_s;
                    op_l_d           = op_sel_s;
                    res_id_d         = sel_idx_s;
                    ptr_d            = ptr_next_s;
                    state_d          = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_data_d  = gate_s;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    done_d      = done_q + 16'd1;
                    state_d     = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= {N_REQ{1'b0}};
            a_l_q       <= {W{1'b0}};
            b_l_q       <= {W{1'b0}};
            op_l_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {W{1'b0}};
            res_id_q    <= {IDW{1'b0}};
            ptr_q       <= {IDW{1'b0}};
            done_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            a_l_q       <= a_l_d;
            b_l_q       <= b_l_d;
            op_l_q      <= op_l_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign done_cnt  = done_q;

endmodule

// File: doc/special_gate_arbiter.md
# special_gate_arbiter

Round-robin arbiter and sequencer that shares one W-bit bank of mux-based XOR/XNOR special gates among N_REQ requesters. It accepts requests through a level req / pulse gnt handshake, latches the granted requester's operands and op select, and evaluates the gate bank. It then presents a registered result with the requester ID to a single downstream consumer under valid/ready flow control. It sits between the requesting datapath blocks and the shared special_gate instances.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 8, operand/result width, i.e. number of special_gate instances in the bank
- IDW, $clog2(N_REQ), requester ID width (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  reset: asynchronous, active-high
- req  input  N_REQ  per-requester request level
- a_in  input  N_REQ*W  operand A; requester k at bits [k*W +: W]
- b_in  input  N_REQ*W  operand B; same packing as a_in
- op_in  input  N_REQ  per-requester op select: 0 = XOR, 1 = XNOR
- gnt  output  N_REQ  one-hot grant, registered, one-cycle pulse
- res_valid  output  1  result valid, registered
- res_data  output  W  gate result, registered
- res_id  output  IDW  index of the requester that owns res_data
- res_ready  input  1  downstream accepts the result
- done_cnt  output  16  count of completed transactions; wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, EXEC, HOLD. Reset state is IDLE.
- IDLE
  - Stays in IDLE while req == 0.
  - With any req bit set, selects the first set bit searching from ptr upward, modulo N_REQ.
  - At the edge: gnt <= onehot(k); a_l, b_l, op_l latch requester k's operands and op select; res_id <= k; ptr <= (k+1) mod N_REQ; state -> EXEC.
- EXEC
  - At the edge: gnt <= 0; res_data <= op_l ? ~(a_l ^ b_l) : (a_l ^ b_l), evaluated bitwise through the gate bank; res_valid <= 1; state -> HOLD.
- HOLD
  - While res_ready == 0, res_valid, res_data and res_id hold.
  - At an edge with res_valid && res_ready: res_valid <= 0; done_cnt <= done_cnt + 1; state -> IDLE.
- Requester protocol
  - A requester holds req, a_in, b_in and op_in stable until it sees gnt.
  - It deasserts req in the cycle after gnt.
  - A req still high when the FSM next enters IDLE is treated as a new request.
- req bits that are not granted are ignored and not stored; no request queue exists.
- Only one transaction is in flight at a time, so no new grant is issued while in EXEC or HOLD.
- ptr reset value is 0. ptr is updated only on a grant.

## Timing
- Reset values: gnt = 0, res_valid = 0, res_data = 0, res_id = 0, done_cnt = 0, ptr = 0, state = IDLE.
- rst asserted in any state clears all outputs immediately, without waiting for a clock edge.
  - An in-flight result is discarded and is not counted.
- Latency, with req sampled high in IDLE at edge E0:
  - gnt is high for the cycle after E0.
  - res_valid rises at E1.
  - With res_ready held high, the earliest res_valid drop is at E2.
  - The earliest next grant is at E3.
- Minimum spacing between grants is 3 cycles. Each cycle of backpressure adds 1 cycle.
- gnt and res_valid are never high in the same cycle.
- res_ready is ignored when res_valid == 0.
- Simultaneous requests are resolved purely by ptr, with no fixed priority.
- done_cnt wraps silently; no overflow flag.

## Test plan
- Reset: drive rst=1 with random req and operands -> gnt = 0, res_valid = 0, res_data = 0x00, done_cnt = 0. Drop rst -> first grant goes to the lowest-index set req.
- Single XOR: req[0]=1, a=0x5A, b=0x0F, op=0, res_ready=1 -> gnt = 4'b0001 one cycle after the sampling edge; next cycle res_valid=1, res_data=0x55, res_id=0; res_valid clears 1 cycle later; done_cnt = 1.
- Single XNOR: req[2]=1, a=0x5A, b=0x0F, op=1 -> res_data = 0xAA, res_id = 2. Repeat all four 1-bit operand combinations in bit 0 with op=0, then op=1 -> XOR 0,1,0,1 and XNOR 1,0,1,0 for ab = 00, 01, 11, 10.
- Round-robin fairness: req=4'b1111 held continuously with res_ready=1 for 8 transactions -> res_id sequence 0,1,2,3,0,1,2,3; grants exactly 3 cycles apart; done_cnt = 8.
- Backpressure: res_ready=0 for 5 cycles with res_valid=1 and req[1] pending -> res_valid, res_data and res_id stable, gnt stays 0. Raise res_ready -> transfer completes, gnt[1] issued 1 cycle after return to IDLE.
- Mid-operation reset: assert rst during EXEC, then during HOLD -> gnt and res_valid go low without a clock edge; done_cnt = 0; ptr restarts at 0. With req=4'b1010 after release, the first grant goes to requester 1.
